usb_host_master: RTL and testbench
==================================

USB_HOST_MASTER -- requirements
Module: usb_host_master

Interface
- REQ-001 The module SHALL have parameter pADDR_WIDTH, default 21, setting the USB address bus width.
- REQ-002 The module SHALL have parameter pSETUP_CYCLES, default 2, setting address/CE-to-strobe cycles (range 1..255).
- REQ-003 The module SHALL have parameter pSTROBE_CYCLES, default 4, setting RDn/WRn low cycles (range 1..255).
- REQ-004 The module SHALL have parameter pHOLD_CYCLES, default 2, setting strobe-release-to-CE-release cycles (range 1..255).
- REQ-005 The module SHALL have these ports:
  - clk_i  in  1  single clock for all logic
  - rst_ni  in  1  reset; asynchronous, active-low
  - cmd_valid_i  in  1  command request
  - cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
  - cmd_write_i  in  1  1 = write, 0 = read
  - cmd_addr_i  in  pADDR_WIDTH  target address
  - cmd_wdata_i  in  8  write byte
  - cmd_trig_i  in  1  trigger request (see Configuration)
  - rsp_valid_o  out  1  one-cycle completion pulse
  - rsp_rdata_o  out  8  last read byte
  - busy_o  out  1  transaction in progress
  - usb_addr_o  out  pADDR_WIDTH  bus address
  - usb_data_o  out  8  bus write data
  - usb_data_oe_o  out  1  data bus drive enable
  - usb_data_i  in  8  bus read data
  - usb_rdn_o  out  1  active-low read strobe
  - usb_wrn_o  out  1  active-low write strobe
  - usb_cen_o  out  1  active-low chip enable
  - usb_trigger_o  out  1  capture trigger

Function
- REQ-006 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD, and all bus outputs SHALL be registered.
- REQ-007 cmd_ready_o SHALL be high only in IDLE; busy_o SHALL be its inverse.
- REQ-008 On accept in cycle N, the module SHALL latch address, data and direction, and SHALL enter SETUP in cycle N+1.
- REQ-009 usb_cen_o SHALL be low from N+1 through N+S+T+H, where S = pSETUP_CYCLES, T = pSTROBE_CYCLES and H = pHOLD_CYCLES.
- REQ-010 usb_addr_o SHALL hold the latched address over the same window.
- REQ-011 usb_rdn_o (read) or usb_wrn_o (write) SHALL be low from N+S+1 through N+S+T; the other strobe SHALL stay high.
- REQ-012 For writes, usb_data_oe_o SHALL be high and usb_data_o SHALL hold the write byte from N+1 through N+S+T+H; for reads, usb_data_oe_o SHALL stay low.
- REQ-013 For reads, usb_data_i SHALL be sampled on the clock edge ending the last STROBE cycle (N+S+T) into rsp_rdata_o.
- REQ-014 rsp_rdata_o SHALL otherwise hold its value; writes SHALL NOT change it.
- REQ-015 rsp_valid_o SHALL pulse high for exactly cycle N+S+T+H+1, the first IDLE cycle, for both reads and writes.
- REQ-016 In IDLE: usb_cen_o, usb_rdn_o and usb_wrn_o SHALL be 1; usb_data_oe_o SHALL be 0; usb_addr_o and usb_data_o SHALL hold their last values.
- REQ-017 Back-to-back: a command valid in the first IDLE cycle SHALL be accepted there, giving exactly one cycle of usb_cen_o high between transactions.
- REQ-018 cmd_* inputs SHALL be ignored outside the accept cycle.
- REQ-019 Cycle counters SHALL be 8-bit; a parameter value of 0 SHALL behave as 1.

Reset
- REQ-020 While rst_ni is low, the module SHALL immediately force IDLE with these outputs: usb_cen_o=1, usb_rdn_o=1, usb_wrn_o=1, usb_data_oe_o=0, usb_addr_o=0, usb_data_o=0, rsp_valid_o=0, rsp_rdata_o=0, usb_trigger_o=0, cmd_ready_o=1, busy_o=0.
- REQ-021 A reset asserted mid-transaction SHALL abort it with no rsp_valid_o pulse.
- REQ-022 After reset release, the first accept SHALL be possible on the first clock edge.

Configuration
- REQ-023 With macro USB_MASTER_TRIGGER_EN defined, usb_trigger_o SHALL be set in the completion cycle (N+S+T+H+1) of a write accepted with cmd_trig_i=1.
- REQ-024 Under USB_MASTER_TRIGGER_EN, usb_trigger_o SHALL be cleared in the cycle after the next accepted command.
- REQ-025 Without USB_MASTER_TRIGGER_EN, cmd_trig_i SHALL be ignored and usb_trigger_o SHALL be constant 0.

Verification (defaults S=2, T=4, H=2)
- REQ-026 Write addr 0x00010, data 0xA5, accepted cycle 0 -> usb_cen_o low cycles 1-8; usb_wrn_o low cycles 3-6; usb_data_o=0xA5 with oe=1 cycles 1-8; rsp_valid_o in cycle 9.
- REQ-027 Read addr 0x00004, bench drives usb_data_i=0x3C in cycles 3-6 -> usb_rdn_o low cycles 3-6, oe=0 throughout, rsp_valid_o cycle 9 with rsp_rdata_o=0x3C.
- REQ-028 cmd_valid_i held high for read-then-write -> second accept in cycle 9, usb_cen_o high only in cycle 9, second strobe low cycles 12-15.
- REQ-029 rst_ni pulled low in cycle 4 of a write -> same-cycle usb_cen_o=1, usb_wrn_o=1, oe=0, no rsp_valid_o; a new command is accepted cleanly after release.
- REQ-030 With USB_MASTER_TRIGGER_EN, write with cmd_trig_i=1 at cycle 0 -> usb_trigger_o high from cycle 9 until the cycle after the next accept; without the macro -> usb_trigger_o stays 0.
- REQ-031 pSTROBE_CYCLES=1, pSETUP_CYCLES=0 -> one-cycle strobe in cycle 2; rsp_valid_o in cycle 5.

Source files
------------

// File: rtl/usb_host_master.sv
// usb_host_master: single-beat master for a USB controller's asynchronous parallel bus.
// Define USB_MASTER_TRIGGER_EN to enable the usb_trigger_o capture trigger.
module usb_host_master #(
  parameter int pADDR_WIDTH    = 21,
  parameter int pSETUP_CYCLES  = 2,
  parameter int pSTROBE_CYCLES = 4,
  parameter int pHOLD_CYCLES   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [pADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]             cmd_wdata_i,
  input  logic                   cmd_trig_i,
  output logic                   rsp_valid_o,
  output logic [7:0]             rsp_rdata_o,
  output logic                   busy_o,
  output logic [pADDR_WIDTH-1:0] usb_addr_o,
  output logic [7:0]             usb_data_o,
  output logic                   usb_data_oe_o,
  input  logic [7:0]             usb_data_i,
  output logic                   usb_rdn_o,
  output logic                   usb_wrn_o,
  output logic                   usb_cen_o,
  output logic                   usb_trigger_o
);

  // A zero-length phase is stretched to one cycle so the counters never underflow.
  localparam logic [7:0] SETUP_LEN  = (pSETUP_CYCLES == 0)  ? 8'd1 : 8'(pSETUP_CYCLES);
  localparam logic [7:0] STROBE_LEN = (pSTROBE_CYCLES == 0) ? 8'd1 : 8'(pSTROBE_CYCLES);
  localparam logic [7:0] HOLD_LEN   = (pHOLD_CYCLES == 0)   ? 8'd1 : 8'(pHOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   cen_q, cen_d;
  logic                   rdn_q, rdn_d;
  logic                   wrn_q, wrn_d;
  logic                   oe_q, oe_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   accept;
  logic                   finish;

  assign accept = (state_q == IDLE) && cmd_valid_i;
  assign finish = (state_q == HOLD) && (cnt_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cen_d       = cen_q;
    rdn_d       = rdn_q;
    wrn_d       = wrn_q;
    oe_d        = oe_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = SETUP;
          cnt_d   = SETUP_LEN - 8'd1;
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          cen_d   = 1'b0;
          oe_d    = cmd_write_i;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LEN - 8'd1;
          rdn_d   = write_q;
          wrn_d   = ~write_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LEN - 8'd1;
          rdn_d   = 1'b1;
          wrn_d   = 1'b1;
          // Read data is captured on the edge that releases the strobe.
          if (!write_q) begin
            rdata_d = usb_data_i;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d     = IDLE;
          cen_d       = 1'b1;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      cen_q       <= 1'b1;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cen_q       <= cen_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef USB_MASTER_TRIGGER_EN
  logic trig_q, trig_d;
  logic trig_arm_q, trig_arm_d;

  // Any accepted command drops the trigger; a triggering write raises it on completion.
  always_comb begin
    trig_d     = trig_q;
    trig_arm_d = trig_arm_q;
    if (accept) begin
      trig_d     = 1'b0;
      trig_arm_d = cmd_write_i & cmd_trig_i;
    end else if (finish && trig_arm_q) begin
      trig_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_q     <= 1'b0;
      trig_arm_q <= 1'b0;
    end else begin
      trig_q     <= trig_d;
      trig_arm_q <= trig_arm_d;
    end
  end

  assign usb_trigger_o = trig_q;
`else
  logic unused_trig;
  logic unused_accept;
  logic unused_finish;
  assign unused_trig   = cmd_trig_i;
  assign unused_accept = accept;
  assign unused_finish = finish;
  assign usb_trigger_o = 1'b0;
`endif

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = ~cmd_ready_o;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign usb_addr_o    = addr_q;
  assign usb_data_o    = wdata_q;
  assign usb_data_oe_o = oe_q;
  assign usb_rdn_o     = rdn_q;
  assign usb_wrn_o     = wrn_q;
  assign usb_cen_o     = cen_q;

endmodule

// File: tb/tb_usb_host_master.sv
// Bench for usb_host_master: window-arithmetic reference model plus directed literal checks.
module tb_usb_host_master;
  localparam int AW = 21;
  localparam int S  = 2;
  localparam int T  = 4;
  localparam int H  = 2;
`ifdef USB_MASTER_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_write_i = 1'b0;
  logic          cmd_trig_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [7:0]    cmd_wdata_i = 8'd0;
  logic [7:0]    usb_data_i = 8'd0;
  logic          cmd_ready_o, rsp_valid_o, busy_o, usb_data_oe_o;
  logic          usb_rdn_o, usb_wrn_o, usb_cen_o, usb_trigger_o;
  logic [7:0]    rsp_rdata_o, usb_data_o;
  logic [AW-1:0] usb_addr_o;

  // second instance: zero setup (treated as one), one-cycle strobe
  logic          b_valid = 1'b0;
  logic          b_write = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [7:0]    b_wdata = 8'd0;
  logic [7:0]    b_data_i = 8'd0;
  logic          b_ready, b_rsp_valid, b_busy, b_oe, b_rdn, b_wrn, b_cen, b_trig;
  logic [7:0]    b_rdata;
  logic [7:0]    unused_b_data;
  logic [AW-1:0] b_usb_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  usb_host_master dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_trig_i(cmd_trig_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
    .usb_addr_o(usb_addr_o), .usb_data_o(usb_data_o), .usb_data_oe_o(usb_data_oe_o),
    .usb_data_i(usb_data_i), .usb_rdn_o(usb_rdn_o), .usb_wrn_o(usb_wrn_o),
    .usb_cen_o(usb_cen_o), .usb_trigger_o(usb_trigger_o)
  );

  usb_host_master #(.pSETUP_CYCLES(0), .pSTROBE_CYCLES(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(b_valid), .cmd_ready_o(b_ready), .cmd_write_i(b_write),
    .cmd_addr_i(b_addr), .cmd_wdata_i(b_wdata), .cmd_trig_i(1'b0),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .busy_o(b_busy),
    .usb_addr_o(b_usb_addr), .usb_data_o(unused_b_data), .usb_data_oe_o(b_oe),
    .usb_data_i(b_data_i), .usb_rdn_o(b_rdn), .usb_wrn_o(b_wrn),
    .usb_cen_o(b_cen), .usb_trigger_o(b_trig)
  );

  task automatic cmp1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic cmpa(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one record of the most recent accepted command.
  bit            have_txn = 1'b0;
  int            n_acc = 0;
  bit            m_write = 1'b0;
  bit            m_trigtx = 1'b0;
  bit            m_trig = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_wdata = 8'd0;
  logic [7:0]    m_rdata = 8'd0;

  function automatic bit m_busy(input int c);
    return have_txn && (c >= n_acc + 1) && (c <= n_acc + S + T + H);
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      have_txn <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= 8'd0;
      m_rdata  <= 8'd0;
      m_trig   <= 1'b0;
      m_trigtx <= 1'b0;
    end else begin
      if (have_txn && !m_write && cyc == n_acc + S + T)
        m_rdata <= usb_data_i;
      if (have_txn && m_write && m_trigtx && cyc == n_acc + S + T + H)
        m_trig <= 1'b1;
      if (cmd_valid_i && !m_busy(cyc)) begin
        have_txn <= 1'b1;
        n_acc    <= cyc;
        m_write  <= cmd_write_i;
        m_addr   <= cmd_addr_i;
        m_wdata  <= cmd_wdata_i;
        m_trigtx <= cmd_trig_i;
        m_trig   <= 1'b0;
        $display("txn cycle %0d: %s addr=%h wdata=%h trig=%b", cyc,
                 cmd_write_i ? "write" : "read ", cmd_addr_i, cmd_wdata_i, cmd_trig_i);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      cmp1("m_rst_ready", cmd_ready_o, 1'b1);
      cmp1("m_rst_busy", busy_o, 1'b0);
      cmp1("m_rst_cen", usb_cen_o, 1'b1);
      cmp1("m_rst_rdn", usb_rdn_o, 1'b1);
      cmp1("m_rst_wrn", usb_wrn_o, 1'b1);
      cmp1("m_rst_oe", usb_data_oe_o, 1'b0);
      cmpa("m_rst_addr", usb_addr_o, '0);
      cmp8("m_rst_data", usb_data_o, 8'd0);
      cmp1("m_rst_rsp_valid", rsp_valid_o, 1'b0);
      cmp8("m_rst_rdata", rsp_rdata_o, 8'd0);
      cmp1("m_rst_trig", usb_trigger_o, 1'b0);
    end else begin
      automatic bit b   = m_busy(cyc);
      automatic bit win = have_txn && (cyc >= n_acc + S + 1) && (cyc <= n_acc + S + T);
      cmp1("m_ready", cmd_ready_o, !b);
      cmp1("m_busy", busy_o, b);
      cmp1("m_cen", usb_cen_o, !b);
      cmp1("m_rdn", usb_rdn_o, !(win && !m_write));
      cmp1("m_wrn", usb_wrn_o, !(win && m_write));
      cmp1("m_oe", usb_data_oe_o, b && m_write);
      cmpa("m_addr", usb_addr_o, m_addr);
      if (b && m_write) cmp8("m_data", usb_data_o, m_wdata);
      cmp1("m_rsp_valid", rsp_valid_o, have_txn && (cyc == n_acc + S + T + H + 1));
      cmp8("m_rdata", rsp_rdata_o, m_rdata);
      cmp1("m_trig", usb_trigger_o, TRIG_EN ? m_trig : 1'b0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp1("rst_ready", cmd_ready_o, 1'b1);
    cmp1("rst_cen", usb_cen_o, 1'b1);
    cmpa("rst_addr", usb_addr_o, '0);

    // write 0x10 <- A5 with trigger, issued in the release cycle
    next_cycle();
    rst_ni = 1'b1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 21'h00010;
    cmd_wdata_i = 8'hA5; cmd_trig_i = 1'b1;
    @(negedge clk);
    cmp1("wr_ready0", cmd_ready_o, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 1) begin
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 21'h1ABCD;
        cmd_wdata_i = 8'hFF; cmd_trig_i = 1'b0;
      end
      @(negedge clk);
      cmp1("wr_cen", usb_cen_o, (k <= 8) ? 1'b0 : 1'b1);
      cmp1("wr_wrn", usb_wrn_o, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
      cmp1("wr_rdn", usb_rdn_o, 1'b1);
      cmp1("wr_rsp_valid", rsp_valid_o, k == 9);
      if (k <= 8) begin
        cmp1("wr_oe", usb_data_oe_o, 1'b1);
        cmp8("wr_data", usb_data_o, 8'hA5);
        cmpa("wr_addr", usb_addr_o, 21'h00010);
      end
      if (k == 9) cmp1("wr_trig_set", usb_trigger_o, TRIG_EN);
    end

    // read 0x4, bus data 3C in cycles 3-6; trig flag on a read must not arm
    next_cycle();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 21'h00004;
    cmd_wdata_i = 8'h11; cmd_trig_i = 1'b1;
    @(negedge clk);
    cmp1("rd_trig_hold", usb_trigger_o, TRIG_EN);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 1) cmd_valid_i = 1'b0;
      usb_data_i = (k >= 3 && k <= 6) ? 8'h3C : 8'hE7;
      @(negedge clk);
      cmp1("rd_rdn", usb_rdn_o, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
      cmp1("rd_wrn", usb_wrn_o, 1'b1);
      cmp1("rd_oe", usb_data_oe_o, 1'b0);
      cmp1("rd_rsp_valid", rsp_valid_o, k == 9);
      if (k == 1) cmp1("rd_trig_clr", usb_trigger_o, 1'b0);
      if (k == 9) begin
        cmp8("rd_rdata", rsp_rdata_o, 8'h3C);
        cmp1("rd_trig_none", usb_trigger_o, 1'b0);
      end
    end

    // back-to-back: read then write with cmd_valid held high
    next_cycle();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 21'h1F00F; cmd_trig_i = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      next_cycle();
      if (k == 1) begin
        cmd_write_i = 1'b1; cmd_addr_i = 21'h00055; cmd_wdata_i = 8'h5A; cmd_trig_i = 1'b1;
      end
      if (k == 10) cmd_valid_i = 1'b0;
      usb_data_i = 8'(64 + k);
      @(negedge clk);
      cmp1("b2b_cen", usb_cen_o, (k == 9) || (k == 18));
      cmp1("b2b_ready", cmd_ready_o, (k == 9) || (k == 18));
      cmp1("b2b_rdn", usb_rdn_o, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
      cmp1("b2b_wrn", usb_wrn_o, (k >= 12 && k <= 15) ? 1'b0 : 1'b1);
      cmp1("b2b_rsp_valid", rsp_valid_o, (k == 9) || (k == 18));
      if (k >= 9) cmp8("b2b_rdata", rsp_rdata_o, 8'h46);
      if (k >= 10 && k <= 17) cmp8("b2b_wdata", usb_data_o, 8'h5A);
      if (k == 18) cmp1("b2b_trig", usb_trigger_o, TRIG_EN);
    end

    // reset during cycle 4 of a write, then a read on the release edge
    next_cycle();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 21'h01234;
    cmd_wdata_i = 8'hC6; cmd_trig_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 1) cmd_valid_i = 1'b0;
      if (k == 4) rst_ni = 1'b0;
      @(negedge clk);
      if (k == 4) begin
        cmp1("ab_cen", usb_cen_o, 1'b1);
        cmp1("ab_wrn", usb_wrn_o, 1'b1);
        cmp1("ab_oe", usb_data_oe_o, 1'b0);
        cmp1("ab_rsp_valid", rsp_valid_o, 1'b0);
        cmpa("ab_addr", usb_addr_o, '0);
        cmp8("ab_rdata", rsp_rdata_o, 8'h00);
        cmp1("ab_ready", cmd_ready_o, 1'b1);
      end
    end
    next_cycle();
    rst_ni = 1'b1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 21'h00007;
    usb_data_i = 8'h99;
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 1) cmd_valid_i = 1'b0;
      @(negedge clk);
      cmp1("pr_cen", usb_cen_o, k == 9);
      cmp1("pr_rsp_valid", rsp_valid_o, k == 9);
      cmp1("pr_rdn", usb_rdn_o, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
      if (k == 9) cmp8("pr_rdata", rsp_rdata_o, 8'h99);
    end

    // second instance: S=0 behaves as 1, T=1
    next_cycle();
    b_valid = 1'b1; b_write = 1'b0; b_addr = 21'h00003;
    @(negedge clk);
    cmp1("s0_ready0", b_ready, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 1) b_valid = 1'b0;
      b_data_i = (k == 2) ? 8'hC3 : 8'h0F;
      @(negedge clk);
      cmp1("s0_cen", b_cen, (k <= 4) ? 1'b0 : 1'b1);
      cmp1("s0_rdn", b_rdn, (k == 2) ? 1'b0 : 1'b1);
      cmp1("s0_wrn", b_wrn, 1'b1);
      cmp1("s0_oe", b_oe, 1'b0);
      cmp1("s0_busy", b_busy, k <= 4);
      cmp1("s0_ready", b_ready, k >= 5);
      cmp1("s0_rsp_valid", b_rsp_valid, k == 5);
      cmp1("s0_trig", b_trig, 1'b0);
      if (k <= 4) cmpa("s0_addr", b_usb_addr, 21'h00003);
      if (k == 5) cmp8("s0_rdata", b_rdata, 8'hC3);
    end

    repeat (3) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
